gcd_unit_responder: RTL and testbench



---
 rtl/gcd_unit_responder_if.sv | 35 +++
 rtl/gcd_unit_responder.sv | 90 +++++++++
 tb/tb_gcd_unit_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gcd_unit_responder_if.sv
// Request/response val/rdy bundle for the GCD responder.
//   req_val  : request valid (initiator -> responder)
//   req_rdy  : request ready (responder -> initiator)
//   req_msg  : {A, B}, each p_nbits wide
//   resp_val : response valid (responder -> initiator)
//   resp_rdy : response ready (initiator -> responder)
//   resp_msg : gcd(A, B)
interface gcd_unit_responder_if #(
    parameter int unsigned p_nbits = 16
) ();
    logic                   req_val;
    logic                   req_rdy;
    logic [2*p_nbits-1:0]   req_msg;
    logic                   resp_val;
    logic                   resp_rdy;
    logic [p_nbits-1:0]     resp_msg;

    modport master (
        output req_val,
        input  req_rdy,
        output req_msg,
        input  resp_val,
        output resp_rdy,
        input  resp_msg
    );

    modport slave (
        input  req_val,
        output req_rdy,
        input  req_msg,
        output resp_val,
        input  resp_rdy,
        output resp_msg
    );
endinterface

// File: rtl/gcd_unit_responder.sv
// Iterative Euclid GCD responder. Accepts {A, B} on the request channel, reduces by
// subtract/swap one step per cycle, and presents gcd(A, B) on the response channel.
// One request in flight; no new request is taken until the response has fired.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   gcd   : request/response bundle (slave side)
//   busy  : high while computing or holding a response
module gcd_unit_responder #(
    parameter int unsigned p_nbits = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    gcd_unit_responder_if.slave   gcd,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [p_nbits-1:0]   a_q, a_d;
    logic [p_nbits-1:0]   b_q, b_d;
    logic                 req_rdy_q, req_rdy_d;
    logic                 resp_val_q, resp_val_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            StIdle: begin
                if (gcd.req_val) begin
                    a_d     = gcd.req_msg[2*p_nbits-1:p_nbits];
                    b_d     = gcd.req_msg[p_nbits-1:0];
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (b_q == '0) begin
                    state_d = StDone;
                end else if (a_q < b_q) begin
                    a_d = b_q;
                    b_d = a_q;
                end else begin
                    // a_q >= b_q here, so this cannot wrap.
                    a_d = a_q - b_q;
                end
            end
            StDone: begin
                if (gcd.resp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of the decode of the next state.
        req_rdy_d  = (state_d == StIdle);
        resp_val_d = (state_d == StDone);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            req_rdy_q  <= req_rdy_d;
            resp_val_q <= resp_val_d;
            busy_q     <= busy_d;
        end
    end

    assign gcd.req_rdy  = req_rdy_q;
    assign gcd.resp_val = resp_val_q;
    assign gcd.resp_msg = a_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_gcd_unit_responder.sv
module tb_gcd_unit_responder;

    logic clk;
    logic reset;
    logic busy;

    int n_tests;
    int n_fail;

    gcd_unit_responder_if #(.p_nbits(16)) gcd ();

    gcd_unit_responder #(
        .p_nbits (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .gcd   (gcd.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the response, optionally stall resp_rdy for
    // `stall` cycles while checking the response holds, then take it.
    // lat = edges from acceptance until resp_val is seen.
    task automatic do_gcd(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input int stall, input int bound,
                          output int lat);
        int viol;
        viol = 0;
        lat  = 0;
        gcd.req_val = 1'b1;
        gcd.req_msg = {a, b};
        step();
        gcd.req_val = 1'b0;
        while (gcd.resp_val !== 1'b1 && lat < bound) begin
            if (gcd.req_rdy !== 1'b0 || busy !== 1'b1) viol++;
            step();
            lat++;
        end
        chk({tag, "_respval"}, 32'(gcd.resp_val), 32'd1);
        chk({tag, "_result"}, 32'(gcd.resp_msg), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            step();
            if (gcd.resp_val !== 1'b1 || gcd.resp_msg !== exp || gcd.req_rdy !== 1'b0) viol++;
        end
        chk({tag, "_busy_hold"}, 32'(viol), 32'd0);
        gcd.resp_rdy = 1'b1;
        step();
        gcd.resp_rdy = 1'b0;
        chk({tag, "_back_idle"}, 32'({gcd.req_rdy, gcd.resp_val, busy}), 32'b100);
    endtask

    initial begin
        int lat;
        int acc;
        int rsp;
        int viol;

        n_tests = 0;
        n_fail  = 0;
        gcd.req_val  = 1'b0;
        gcd.req_msg  = '0;
        gcd.resp_rdy = 1'b0;
        reset = 1'b0;
        #12;
        chk("rst_req_rdy", 32'(gcd.req_rdy), 32'd1);
        chk("rst_resp_val", 32'(gcd.resp_val), 32'd0);
        chk("rst_resp_msg", 32'(gcd.resp_msg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Basic
        do_gcd("g15_5", 16'd15, 16'd5, 16'd5, 0, 100, lat);
        chk("g15_5_latency", 32'(lat), 32'd5);
        do_gcd("g9_3", 16'd9, 16'd3, 16'd3, 0, 100, lat);
        chk("g9_3_latency", 32'(lat), 32'd5);
        do_gcd("g27_15", 16'd27, 16'd15, 16'd3, 0, 100, lat);
        chk("g27_15_latency", 32'(lat), 32'd10);
        do_gcd("g21_49", 16'd21, 16'd49, 16'd7, 0, 200, lat);

        // Zero / identity
        do_gcd("g0_0", 16'd0, 16'd0, 16'd0, 0, 100, lat);
        chk("g0_0_latency", 32'(lat), 32'd1);
        do_gcd("g0_7", 16'd0, 16'd7, 16'd7, 0, 100, lat);
        chk("g0_7_latency", 32'(lat), 32'd2);
        do_gcd("g7_0", 16'd7, 16'd0, 16'd7, 0, 100, lat);
        do_gcd("g1_1", 16'd1, 16'd1, 16'd1, 0, 100, lat);
        do_gcd("gmax_max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 100, lat);

        // Backpressure: response must hold while resp_rdy is low
        do_gcd("bp48_18", 16'd48, 16'd18, 16'd6, 3, 200, lat);
        do_gcd("bp100_75", 16'd100, 16'd75, 16'd25, 7, 200, lat);
        do_gcd("bp17_13", 16'd17, 16'd13, 16'd1, 1, 200, lat);

        // Worst-case latency
        do_gcd("gmax_1", 16'hFFFF, 16'd1, 16'd1, 0, 70000, lat);
        chk("gmax_1_latency", 32'(lat), 32'd65537);

        // Mid-op reset
        gcd.req_val = 1'b1;
        gcd.req_msg = {16'd48, 16'd18};
        step();
        gcd.req_val = 1'b0;
        step();
        step();
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({gcd.req_rdy, gcd.resp_val, busy}), 32'b100);
        chk("mid_rst_resp_msg", 32'(gcd.resp_msg), 32'd0);
        step();
        reset = 1'b1;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gcd.resp_val !== 1'b0 || busy !== 1'b0) viol++;
        end
        chk("mid_no_resp", 32'(viol), 32'd0);
        do_gcd("mid_retry", 16'd48, 16'd18, 16'd6, 0, 200, lat);

        // Protocol: req_val held high, one accept per response
        gcd.req_val  = 1'b1;
        gcd.req_msg  = {16'd9, 16'd3};
        gcd.resp_rdy = 1'b1;
        acc  = 0;
        rsp  = 0;
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            if (gcd.req_val && gcd.req_rdy) acc++;
            if (gcd.resp_val && gcd.resp_rdy) begin
                rsp++;
                if (gcd.resp_msg !== 16'd3) viol++;
            end
            if (gcd.req_rdy !== !busy) viol++;
            if (gcd.req_rdy === 1'b1 && gcd.resp_val !== 1'b0) viol++;
            step();
        end
        gcd.req_val  = 1'b0;
        gcd.resp_rdy = 1'b0;
        chk("proto_accepts", 32'(acc), 32'd6);
        chk("proto_responses", 32'(rsp), 32'd5);
        chk("proto_rdy_busy", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
